// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the PC register and the IF/ID pipeline
// register. It fetches from instruction memory with at most one request
// outstanding, follows downstream stall (holdpc) and branch/jump redirects,
// and parks a response that arrives during a stall in a one-entry skid buffer.
//
// Ports
//   clk                : rising-edge clock
//   rst                : asynchronous, active-low reset
//   holdpc             : stall, freezes PC and IF/ID
//   redirect           : taken branch/jump, flushes IF/ID and loads redirect_pc
//   redirect_pc[31:0]  : redirect target (bits [1:0] forced to 00)
//   imem_req           : fetch request valid
//   imem_addr[31:0]    : fetch address (the PC register)
//   imem_ready         : memory accepts the request this cycle
//   imem_rvalid        : response data valid
//   imem_rdata[31:0]   : fetched instruction
//   if_id_instruction  : IF/ID instruction
//   if_id_pc           : PC of if_id_instruction
//   if_id_valid        : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        holdpc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] skid, skid_nxt;
   logic [31:0] instr_nxt;
   logic [31:0] ifpc_nxt;
   logic        valid_nxt;
   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        outstanding;

   assign target    = {redirect_pc[31:2], 2'b00};
   assign pc_inc    = pc + 32'd4;   // wraps modulo 2^32
   assign imem_addr = pc;

   // A response is still owed to us after this cycle: the memory has
   // accepted (or already holds) a request whose data has not yet returned.
   // S_DROP keeps waiting for its owed response too, so a redirect there
   // stays in S_DROP unless that response is arriving right now.
   assign outstanding = ((state == S_WAIT) && !imem_rvalid) ||
                        ((state == S_REQ)  &&  imem_ready)  ||
                        ((state == S_DROP) && !imem_rvalid);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      skid_nxt  = skid;
      instr_nxt = if_id_instruction;
      ifpc_nxt  = if_id_pc;
      valid_nxt = if_id_valid;
      imem_req  = 1'b0;

      case (state)
         S_BOOT: begin
            state_nxt = S_REQ;
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (!holdpc) begin
                  instr_nxt = imem_rdata;
                  ifpc_nxt  = pc;
                  valid_nxt = 1'b1;
                  pc_nxt    = pc_inc;
                  state_nxt = S_REQ;
               end else begin
                  skid_nxt  = imem_rdata;
                  state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!holdpc) begin
               instr_nxt = skid;
               ifpc_nxt  = pc;
               valid_nxt = 1'b1;
               pc_nxt    = pc_inc;
               skid_nxt  = 32'd0;
               state_nxt = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: begin
            state_nxt = S_BOOT;
         end
      endcase

      // Redirect overrides stall and any same-cycle response. In S_BOOT the
      // IF/ID register already holds the bubble, so only the PC moves.
      if (redirect) begin
         pc_nxt = target;
         if (state != S_BOOT) begin
            instr_nxt = NOP_INSTR;
            ifpc_nxt  = 32'd0;
            valid_nxt = 1'b0;
            skid_nxt  = 32'd0;
            state_nxt = outstanding ? S_DROP : S_REQ;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= S_BOOT;
         pc                <= RESET_PC;
         skid              <= 32'd0;
         if_id_instruction <= NOP_INSTR;
         if_id_pc          <= 32'd0;
         if_id_valid       <= 1'b0;
      end else begin
         state             <= state_nxt;
         pc                <= pc_nxt;
         skid              <= skid_nxt;
         if_id_instruction <= instr_nxt;
         if_id_pc          <= ifpc_nxt;
         if_id_valid       <= valid_nxt;
      end
   end

endmodule
